// File: rtl/mux_scanner.sv
// Sequences the select lines of a downstream 4:1 mux and collects its output into a 4-bit frame.
// Each frame is presented with a valid/ready handshake and may be followed immediately by another scan.
module mux_scanner #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       Y,
    output logic       S0,
    output logic       S1,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_OUTPUT
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] buf_q, buf_d;
    logic [3:0] frame_q, frame_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    // NOTE: the sample buffer is a handful of flops, so it is reset like everything else;
    // an interrupted scan must leave no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= 4'd0;
            buf_q   <= 4'd0;
            frame_q <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        frame_d = frame_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    ch_d    = 2'd0;
                    cnt_d   = RELOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    buf_d[ch_q] = Y;
                    if (ch_q == 2'd3) begin
                        frame_d = buf_d;
                        valid_d = 1'b1;
                        state_d = ST_OUTPUT;
                    end else begin
                        ch_d  = ch_q + 2'd1;
                        cnt_d = RELOAD;
                    end
                end
            end
            ST_OUTPUT: begin
                // continuous only matters at the handshake edge
                if (valid_q && frame_ready) begin
                    valid_d = 1'b0;
                    ch_d    = 2'd0;
                    if (continuous) begin
                        state_d = ST_SETTLE;
                        cnt_d   = RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = 2'd0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign S0          = ch_q[0];
    assign S1          = ch_q[1];
    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Drives two scanners (SETTLE=2 and SETTLE=0) against a timeline-based reference model,
// with directed scenarios followed by randomized traffic.
module tb_mux_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic       frame_ready;
    logic [3:0] mux_in;

    logic       y_i         [2];
    logic       s0_o        [2];
    logic       s1_o        [2];
    logic [3:0] frame_o     [2];
    logic       frame_valid_o [2];
    logic       busy_o      [2];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: mode 0 idle, 1 scanning, 2 presenting
    int         per    [2] = '{3, 1};
    int         m_mode [2];
    int         m_el   [2];
    logic [3:0] m_buf  [2];
    logic [3:0] m_frame[2];

    always #5 clk = ~clk;

    assign y_i[0] = mux_in[{s1_o[0], s0_o[0]}];
    assign y_i[1] = mux_in[{s1_o[1], s0_o[1]}];

    mux_scanner #(.SETTLE(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .Y          (y_i[0]),
        .S0         (s0_o[0]),
        .S1         (s1_o[0]),
        .frame      (frame_o[0]),
        .frame_valid(frame_valid_o[0]),
        .frame_ready(frame_ready),
        .busy       (busy_o[0])
    );

    mux_scanner #(.SETTLE(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .Y          (y_i[1]),
        .S0         (s0_o[1]),
        .S1         (s1_o[1]),
        .frame      (frame_o[1]),
        .frame_valid(frame_valid_o[1]),
        .frame_ready(frame_ready),
        .busy       (busy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs that the DUTs are about to sample.
    task automatic model_edge();
        int n;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i]  = 0;
                m_el[i]    = 0;
                m_buf[i]   = 4'd0;
                m_frame[i] = 4'd0;
            end else begin
                case (m_mode[i])
                    0: if (start) begin
                        m_mode[i] = 1;
                        m_el[i]   = 0;
                    end
                    1: begin
                        m_el[i]++;
                        if (m_el[i] % per[i] == 0) begin
                            n = m_el[i] / per[i] - 1;
                            m_buf[i][n] = mux_in[n];
                            if (n == 3) begin
                                m_frame[i] = m_buf[i];
                                m_mode[i]  = 2;
                            end
                        end
                    end
                    default: if (frame_ready) begin
                        m_mode[i] = continuous ? 1 : 0;
                        m_el[i]   = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic tick();
        int exp_s;
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_s = (m_mode[i] == 0) ? 0 : (m_mode[i] == 2) ? 3 : m_el[i] / per[i];
            check($sformatf("S[%0d]", i), 32'({s1_o[i], s0_o[i]}), 32'(exp_s));
            check($sformatf("frame_valid[%0d]", i), 32'(frame_valid_o[i]), 32'(m_mode[i] == 2));
            check($sformatf("frame[%0d]", i), 32'(frame_o[i]), 32'(m_frame[i]));
            check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_mode[i] != 0));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int lat2;
        int lat0;

        rst         = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        frame_ready = 1'b1;
        mux_in      = 4'b1010;
        #2;
        ticks(2);
        rst = 1'b0;
        ticks(3);

        // single scan, latency measured from the start edge
        start = 1'b1;
        tick();
        start = 1'b0;
        lat2 = -1;
        lat0 = -1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (frame_valid_o[0] && lat2 < 0) lat2 = k;
            if (frame_valid_o[1] && lat0 < 0) lat0 = k;
        end
        check("latency_settle2", 32'(lat2), 32'd12);
        check("latency_settle0", 32'(lat0), 32'd4);
        check("scan_frame", 32'(frame_o[0]), 32'b1010);

        // backpressure: frame held while frame_ready is low
        frame_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(17);
        frame_ready = 1'b1;
        ticks(3);

        // continuous scans with the mux inputs changing before channel 0 is sampled
        continuous = 1'b1;
        mux_in = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(13);
        mux_in = 4'b0101;
        ticks(14);
        continuous = 1'b0;
        ticks(20);
        check("continuous_frame", 32'(frame_o[0]), 32'b0101);

        // reset in the middle of a scan
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(15);

        // starts while busy are dropped
        mux_in = 4'b0110;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            start = (k == 3 || k == 8);
            tick();
        end
        start = 1'b0;
        ticks(10);

        // SETTLE=0 corner with all ones
        mux_in = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(15);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            start       = ($urandom_range(7) == 0);
            continuous  = ($urandom_range(3) == 0);
            frame_ready = ($urandom_range(1) == 0);
            rst         = ($urandom_range(199) == 0);
            mux_in      = 4'($urandom_range(15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
